comp_event_filter: RTL

//  Downstream stage of the magnitude comparator. Samples its gt/eq/lt flags on
//  a strobe and debounces them: a relation is committed only after FILTER_LEN

---
 rtl/comp_event_filter_if.sv | 26 ++
 rtl/comp_event_filter.sv | 118 +++++++++++
 2 files changed

// File: rtl/comp_event_filter_if.sv
// Bundles the comparator flag inputs, sample/clear controls and the filtered
// relation outputs of comp_event_filter.
interface comp_event_filter_if #(
   parameter int unsigned CNT_WIDTH = 8
) ();
   logic                 en;
   logic                 gt;
   logic                 eq;
   logic                 lt;
   logic                 clr;
   logic [1:0]           state;
   logic                 up_pulse;
   logic                 down_pulse;
   logic [CNT_WIDTH-1:0] cross_cnt;
   logic                 err;

   modport master (
      output en, gt, eq, lt, clr,
      input  state, up_pulse, down_pulse, cross_cnt, err
   );

   modport slave (
      input  en, gt, eq, lt, clr,
      output state, up_pulse, down_pulse, cross_cnt, err
   );
endinterface

// File: rtl/comp_event_filter.sv
// Debounces comparator gt/eq/lt flags into a committed relation, with
// direction pulses, a saturating transition counter and a sticky error flag.
module comp_event_filter #(
   parameter int unsigned FILTER_LEN = 3,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input logic                i_clk,
   input logic                i_rst_n,
   comp_event_filter_if.slave bus
);

   // Encoding doubles as rank: BELOW < EQUAL < ABOVE numerically.
   typedef enum logic [1:0] {
      RelUnknown = 2'b00,
      RelBelow   = 2'b01,
      RelEqual   = 2'b10,
      RelAbove   = 2'b11
   } rel_e;

   localparam int unsigned RunW = $clog2(FILTER_LEN + 1);

   rel_e                 r_state;
   rel_e                 r_cand;
   logic [RunW-1:0]      r_run;
   logic                 r_up;
   logic                 r_down;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_err;

   logic [2:0]           w_flags;
   logic                 w_onehot;
   logic                 w_valid;
   logic                 w_invalid;
   rel_e                 w_code;
   rel_e                 w_cand_d;
   logic [RunW-1:0]      w_run_d;
   logic                 w_commit;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_inc;

   assign w_flags   = {bus.gt, bus.eq, bus.lt};
   assign w_onehot  = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
   assign w_valid   = bus.en & w_onehot;
   assign w_invalid = bus.en & ~w_onehot;

   always_comb begin
      w_code = RelUnknown;
      unique case (w_flags)
         3'b100:  w_code = RelAbove;
         3'b010:  w_code = RelEqual;
         3'b001:  w_code = RelBelow;
         default: w_code = RelUnknown;
      endcase
   end

   always_comb begin
      w_cand_d = r_cand;
      w_run_d  = r_run;
      if (w_invalid) begin
         w_cand_d = RelUnknown;
         w_run_d  = '0;
      end else if (w_valid) begin
         if (w_code == r_cand) begin
            if (r_run < RunW'(FILTER_LEN)) begin
               w_run_d = r_run + RunW'(1);
            end
         end else begin
            w_cand_d = w_code;
            w_run_d  = RunW'(1);
         end
      end
   end

   // Commit uses the post-sample run so FILTER_LEN=1 commits on the sampling edge.
   assign w_commit = w_valid && (w_run_d == RunW'(FILTER_LEN)) && (w_cand_d != r_state);
   assign w_rise   = w_commit && (r_state != RelUnknown) && (w_cand_d > r_state);
   assign w_fall   = w_commit && (r_state != RelUnknown) && (w_cand_d < r_state);
   assign w_inc    = w_rise | w_fall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RelUnknown;
         r_cand  <= RelUnknown;
         r_run   <= '0;
         r_up    <= 1'b0;
         r_down  <= 1'b0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_cand <= w_cand_d;
         r_run  <= w_run_d;
         r_up   <= w_rise;
         r_down <= w_fall;
         if (w_commit) begin
            r_state <= w_cand_d;
         end
         if (bus.clr) begin
            r_cnt <= '0;
         end else if (w_inc && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
         // A fresh error outranks a clear in the same cycle.
         if (w_invalid) begin
            r_err <= 1'b1;
         end else if (bus.clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bus.state      = r_state;
   assign bus.up_pulse   = r_up;
   assign bus.down_pulse = r_down;
   assign bus.cross_cnt  = r_cnt;
   assign bus.err        = r_err;

endmodule
